// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: PLL power-up/lock sequencer with lock qualification, timeout retry and loss recovery.
// Optional lock-loss event counter enabled by defining PLL_SEQ_LOSS_CNT_EN.
module pll_lock_sequencer #(
    parameter int               RESET_CYCLES        = 16,
    parameter int               LOCK_STABLE_CYCLES  = 1024,
    parameter int               LOCK_TIMEOUT_CYCLES = 65535,
    parameter int               MAX_RETRIES         = 3,
    parameter logic [3:0]       CLKOUT_MASK         = 4'b0011,
    parameter int               CNT_W               = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic       clr_fault,
    input  logic       pll_lock,
    output logic       pll_en,
    output logic       pll_resetn,
    output logic [3:0] clkout_en,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    typedef enum logic [2:0] {
        S_OFF, S_RESET, S_WAIT, S_STABLE, S_RUN, S_FAULT
    } state_t;

    state_t             state, nxt;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         retry_d;
    logic               lock_q1, lock_s;
    logic               pll_en_d, pll_resetn_d, ready_d, fault_d;
    logic [3:0]         clkout_en_d;

    // two-flop synchroniser for the raw PLL lock
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) {lock_s, lock_q1} <= 2'b00;
        else         {lock_s, lock_q1} <= {lock_q1, pll_lock};

    // state, shared cycle counter (cleared on every state change) and retry count
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            state     <= S_OFF;
            cnt       <= '0;
            retry_cnt <= 4'd0;
        end else begin
            state     <= nxt;
            cnt       <= (nxt != state) ? '0 : cnt + CNT_W'(1);
            retry_cnt <= retry_d;
        end

    // next state; a dropped enable overrides everything else
    always_comb begin
        nxt = state;
        case (state)
            S_OFF:    nxt = enable ? S_RESET : S_OFF;
            S_RESET:  nxt = (cnt == CNT_W'(RESET_CYCLES - 1)) ? S_WAIT : S_RESET;
            S_WAIT:   nxt = lock_s ? S_STABLE :
                            (cnt != CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) ? S_WAIT :
                            (retry_cnt < 4'(MAX_RETRIES)) ? S_RESET : S_FAULT;
            S_STABLE: nxt = !lock_s ? S_WAIT :
                            (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) ? S_RUN : S_STABLE;
            S_RUN:    nxt = lock_s ? S_RUN : S_RESET;
            S_FAULT:  nxt = clr_fault ? S_OFF : S_FAULT;
            default:  nxt = S_OFF;
        endcase
        if (!enable) nxt = S_OFF;
    end

    // retry bookkeeping follows the chosen transition, so a disable leaves it untouched
    always_comb begin
        retry_d = retry_cnt;
        if (state == S_OFF && nxt == S_RESET) retry_d = 4'd0;
        if (state == S_WAIT && nxt == S_RESET) retry_d = retry_cnt + 4'd1;
        if (state == S_RUN && nxt == S_RESET) retry_d = 4'd0;
    end

    // output decode from the next state so outputs change on the same edge as the state
    always_comb begin
        pll_en_d     = nxt inside {S_RESET, S_WAIT, S_STABLE, S_RUN};
        pll_resetn_d = nxt inside {S_WAIT, S_STABLE, S_RUN};
        clkout_en_d  = (nxt == S_RUN) ? CLKOUT_MASK : 4'b0000;
        ready_d      = nxt == S_RUN;
        fault_d      = nxt == S_FAULT;
    end

    // registered outputs; async reset forces clock enables low without a clock edge
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            pll_en     <= 1'b0;
            pll_resetn <= 1'b0;
            clkout_en  <= 4'b0000;
            ready      <= 1'b0;
            fault      <= 1'b0;
        end else begin
            pll_en     <= pll_en_d;
            pll_resetn <= pll_resetn_d;
            clkout_en  <= clkout_en_d;
            ready      <= ready_d;
            fault      <= fault_d;
        end

`ifdef PLL_SEQ_LOSS_CNT_EN
    logic loss_evt;
    assign loss_evt = (state == S_RUN) && (nxt == S_RESET);

    // saturating count of lock-loss events seen in RUN
    always_ff @(posedge clk or negedge resetn)
        if (!resetn)                            loss_cnt <= 8'h00;
        else if (loss_evt && loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'h01;
`else
    assign loss_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed bench for the PLL lock sequencer (small cycle parameters).
module tb_pll_lock_sequencer;

    logic       clk = 1'b0;
    logic       resetn, enable, clr_fault, pll_lock;
    logic       pll_en, pll_resetn, ready, fault;
    logic [3:0] clkout_en, retry_cnt;
    logic [7:0] loss_cnt;
    int         checks = 0, failures = 0, cyc = 0;

`ifdef PLL_SEQ_LOSS_CNT_EN
    localparam logic [7:0] LOSS1 = 8'd1;
`else
    localparam logic [7:0] LOSS1 = 8'd0;
`endif

    pll_lock_sequencer #(
        .RESET_CYCLES(4), .LOCK_STABLE_CYCLES(8), .LOCK_TIMEOUT_CYCLES(32),
        .MAX_RETRIES(2), .CLKOUT_MASK(4'b0011), .CNT_W(16)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .clr_fault(clr_fault),
        .pll_lock(pll_lock), .pll_en(pll_en), .pll_resetn(pll_resetn),
        .clkout_en(clkout_en), .ready(ready), .fault(fault),
        .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic chk_off(input string tag);
        chk({tag, "_pll_en"}, 32'(pll_en), 32'd0);
        chk({tag, "_pll_resetn"}, 32'(pll_resetn), 32'd0);
        chk({tag, "_clkout_en"}, 32'(clkout_en), 32'd0);
        chk({tag, "_ready"}, 32'(ready), 32'd0);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
    endtask

    initial begin
        resetn = 1'b0; enable = 1'b0; clr_fault = 1'b0; pll_lock = 1'b0;
        #3;
        chk_off("rst");
        chk("rst_retry", 32'(retry_cnt), 32'd0);
        chk("rst_loss", 32'(loss_cnt), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        enable = 1'b1;
        // nominal bring-up
        step();
        chk("nom_pll_en", 32'(pll_en), 32'd1);
        chk("nom_rstn_low", 32'(pll_resetn), 32'd0);
        wait_to(4);
        chk("nom_rstn_c4", 32'(pll_resetn), 32'd0);
        wait_to(5);
        chk("nom_rstn_c5", 32'(pll_resetn), 32'd1);
        wait_to(15);
        pll_lock = 1'b1;
        wait_to(25);
        chk("nom_ready_c25", 32'(ready), 32'd0);
        chk("nom_clkout_c25", 32'(clkout_en), 32'd0);
        wait_to(26);
        chk("nom_ready_c26", 32'(ready), 32'd1);
        chk("nom_clkout_c26", 32'(clkout_en), 32'd3);
        chk("nom_retry", 32'(retry_cnt), 32'd0);
        // one-cycle lock loss in RUN
        pll_lock = 1'b0;
        wait_to(27);
        pll_lock = 1'b1;
        wait_to(28);
        chk("loss_ready_c28", 32'(ready), 32'd1);
        wait_to(29);
        chk("loss_ready_c29", 32'(ready), 32'd0);
        chk("loss_clkout_c29", 32'(clkout_en), 32'd0);
        chk("loss_rstn_c29", 32'(pll_resetn), 32'd0);
        chk("loss_pll_en_c29", 32'(pll_en), 32'd1);
        chk("loss_cnt", 32'(loss_cnt), 32'(LOSS1));
        wait_to(41);
        chk("reseq_ready_c41", 32'(ready), 32'd0);
        wait_to(42);
        chk("reseq_ready_c42", 32'(ready), 32'd1);
        // lock loss and disable in the same cycle
        pll_lock = 1'b0;
        wait_to(44);
        chk("same_ready_c44", 32'(ready), 32'd1);
        enable = 1'b0;
        wait_to(45);
        chk_off("same");
        chk("same_loss", 32'(loss_cnt), 32'(LOSS1));
        // lock bounce in STABLE
        enable = 1'b1;
        wait_to(50);
        chk("bnc_rstn_c50", 32'(pll_resetn), 32'd1);
        pll_lock = 1'b1;
        wait_to(55);
        pll_lock = 1'b0;
        wait_to(56);
        pll_lock = 1'b1;
        wait_to(61);
        chk("bnc_ready_c61", 32'(ready), 32'd0);
        wait_to(66);
        chk("bnc_ready_c66", 32'(ready), 32'd0);
        wait_to(67);
        chk("bnc_ready_c67", 32'(ready), 32'd1);
        chk("bnc_retry", 32'(retry_cnt), 32'd0);
        // disable in RUN
        enable = 1'b0;
        wait_to(68);
        chk_off("dis_run");
        // disable in STABLE
        enable = 1'b1;
        wait_to(76);
        chk("dis_stb_rstn_c76", 32'(pll_resetn), 32'd1);
        enable = 1'b0;
        wait_to(77);
        chk_off("dis_stb");
        // timeout, retries, fault
        enable = 1'b1;
        pll_lock = 1'b0;
        wait_to(113);
        chk("to_rstn_c113", 32'(pll_resetn), 32'd1);
        chk("to_retry_c113", 32'(retry_cnt), 32'd0);
        wait_to(114);
        chk("to_rstn_c114", 32'(pll_resetn), 32'd0);
        chk("to_pll_en_c114", 32'(pll_en), 32'd1);
        chk("to_retry_c114", 32'(retry_cnt), 32'd1);
        wait_to(118);
        chk("to_rstn_c118", 32'(pll_resetn), 32'd1);
        wait_to(150);
        chk("to_retry_c150", 32'(retry_cnt), 32'd2);
        chk("to_rstn_c150", 32'(pll_resetn), 32'd0);
        wait_to(185);
        chk("to_fault_c185", 32'(fault), 32'd0);
        wait_to(186);
        chk("to_fault_c186", 32'(fault), 32'd1);
        chk("to_pll_en_c186", 32'(pll_en), 32'd0);
        chk("to_rstn_c186", 32'(pll_resetn), 32'd0);
        chk("to_retry_c186", 32'(retry_cnt), 32'd2);
        wait_to(190);
        chk("to_fault_c190", 32'(fault), 32'd1);
        clr_fault = 1'b1;
        wait_to(191);
        clr_fault = 1'b0;
        chk_off("clr");
        wait_to(192);
        chk("clr_pll_en_c192", 32'(pll_en), 32'd1);
        chk("clr_retry_c192", 32'(retry_cnt), 32'd0);
        // async reset in WAIT_LOCK
        wait_to(200);
        chk("ar_rstn_c200", 32'(pll_resetn), 32'd1);
        #1;
        resetn = 1'b0;
        #1;
        chk_off("ar");
        chk("ar_retry", 32'(retry_cnt), 32'd0);
        chk("ar_loss", 32'(loss_cnt), 32'd0);
        #3;
        resetn = 1'b1;
        step();
        chk("ar_pll_en_c201", 32'(pll_en), 32'd1);
        chk("ar_rstn_c201", 32'(pll_resetn), 32'd0);
        wait_to(205);
        chk("ar_rstn_c205", 32'(pll_resetn), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
